// File: rtl/overlay_read_sequencer_pkg.sv
// Shared types and constants for the overlay read path.
package overlay_read_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ACTIVE    = 2'd1,
    FRAME_END = 2'd2
  } seq_state_e;

  localparam int unsigned STALL_W = 16;

  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_H_ACTIVE   = 640;
  localparam int unsigned DEF_V_ACTIVE   = 480;
  localparam int unsigned DEF_OVL_X      = 0;
  localparam int unsigned DEF_OVL_Y      = 0;
  localparam int unsigned DEF_OVL_W      = 64;
  localparam int unsigned DEF_OVL_H      = 64;

  // Half-open range test lo <= v < hi on pre-truncated bounds.
  function automatic logic in_span(input int unsigned v, input int unsigned lo,
                                   input int unsigned hi);
    return (v >= lo) && (v < hi);
  endfunction

endpackage

// File: rtl/overlay_read_sequencer_pixel_position_counter.sv
// Raster x/y counters with end-of-line, last-pixel and overlay-window flags.
module pixel_position_counter
  import overlay_read_sequencer_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned OVL_X    = DEF_OVL_X,
  parameter int unsigned OVL_Y    = DEF_OVL_Y,
  parameter int unsigned OVL_W    = DEF_OVL_W,
  parameter int unsigned OVL_H    = DEF_OVL_H,
  parameter int unsigned XW       = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1,
  parameter int unsigned YW       = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          advance,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          eol,
  output logic          last_pix,
  output logic          inwin
);

  localparam int unsigned XW1 = XW + 1;
  localparam int unsigned YW1 = YW + 1;

  // Window bounds at counter width; the end bound gets one extra bit.
  localparam logic [XW-1:0] X_BEG = XW'(OVL_X);
  localparam logic [XW1-1:0] X_END = XW1'(OVL_X + OVL_W);
  localparam logic [YW-1:0] Y_BEG = YW'(OVL_Y);
  localparam logic [YW1-1:0] Y_END = YW1'(OVL_Y + OVL_H);

  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;

  assign x        = x_q;
  assign y        = y_q;
  assign eol      = (x_q == XW'(H_ACTIVE - 1));
  assign last_pix = eol && (y_q == YW'(V_ACTIVE - 1));
  assign inwin    = in_span(32'(x_q), 32'(X_BEG), 32'(X_END)) &&
                    in_span(32'(y_q), 32'(Y_BEG), 32'(Y_END));

  // Raster advance; the last pixel wraps both counters back to the origin.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (advance) begin
      if (eol) begin
        x_d = '0;
        y_d = last_pix ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

endmodule

// File: rtl/overlay_read_sequencer.sv
// Pops background/overlay FIFOs along the raster and registers handshaked pixel pairs.
module overlay_read_sequencer
  import overlay_read_sequencer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned H_ACTIVE   = DEF_H_ACTIVE,
  parameter int unsigned V_ACTIVE   = DEF_V_ACTIVE,
  parameter int unsigned OVL_X      = DEF_OVL_X,
  parameter int unsigned OVL_Y      = DEF_OVL_Y,
  parameter int unsigned OVL_W      = DEF_OVL_W,
  parameter int unsigned OVL_H      = DEF_OVL_H
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  ENABLE,
  input  logic                  BG_EMPTY,
  input  logic [DATA_WIDTH-1:0] BG_DATA,
  output logic                  BG_READ,
  input  logic                  OV_EMPTY,
  input  logic [DATA_WIDTH-1:0] OV_DATA,
  output logic                  OV_READ,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY,
  output logic [DATA_WIDTH-1:0] OUT_BG,
  output logic [DATA_WIDTH-1:0] OUT_OV,
  output logic                  OUT_OV_SEL,
  output logic                  OUT_SOF,
  output logic                  OUT_EOL,
  output logic                  FRAME_DONE,
  output logic [STALL_W-1:0]    STALL_COUNT
);

  localparam int unsigned XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int unsigned YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;

  seq_state_e state_q, state_d;

  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_bg_q, out_bg_d;
  logic [DATA_WIDTH-1:0] out_ov_q, out_ov_d;
  logic                  out_sel_q, out_sel_d;
  logic                  out_sof_q, out_sof_d;
  logic                  out_eol_q, out_eol_d;
  logic [STALL_W-1:0]    stall_q, stall_d;

  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic          eol, last_pix, inwin;
  logic          slot_free, need_ov, load, starved;

  pixel_position_counter #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE),
    .OVL_X    (OVL_X),
    .OVL_Y    (OVL_Y),
    .OVL_W    (OVL_W),
    .OVL_H    (OVL_H),
    .XW       (XW),
    .YW       (YW)
  ) u_pos (
    .clk      (CLK),
    .rst      (RESET),
    .advance  (load),
    .x        (x),
    .y        (y),
    .eol      (eol),
    .last_pix (last_pix),
    .inwin    (inwin)
  );

  assign slot_free = !out_valid_q || OUT_READY;
  assign need_ov   = inwin;

  // Frame FSM and load decision; reset suppresses any pop in its own cycle.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    starved = 1'b0;
    case (state_q)
      IDLE: begin
        if (ENABLE) state_d = ACTIVE;
      end
      ACTIVE: begin
        load    = slot_free && !BG_EMPTY && (!need_ov || !OV_EMPTY);
        starved = slot_free && !load;
        if (load && last_pix) state_d = FRAME_END;
      end
      FRAME_END: begin
        state_d = ENABLE ? ACTIVE : IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (RESET) begin
      load    = 1'b0;
      starved = 1'b0;
    end
  end

  // Output pair register: load has priority over pop, otherwise hold.
  always_comb begin
    out_valid_d = out_valid_q;
    out_bg_d    = out_bg_q;
    out_ov_d    = out_ov_q;
    out_sel_d   = out_sel_q;
    out_sof_d   = out_sof_q;
    out_eol_d   = out_eol_q;
    if (load) begin
      out_valid_d = 1'b1;
      out_bg_d    = BG_DATA;
      out_ov_d    = need_ov ? OV_DATA : '0;
      out_sel_d   = need_ov;
      out_sof_d   = (x == '0) && (y == '0);
      out_eol_d   = eol;
    end else if (out_valid_q && OUT_READY) begin
      out_valid_d = 1'b0;
    end
  end

  // Saturating starved-cycle counter.
  always_comb begin
    stall_d = stall_q;
    if (starved && (stall_q != '1)) stall_d = stall_q + 1'b1;
  end

  // State, output and stall registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      out_bg_q    <= '0;
      out_ov_q    <= '0;
      out_sel_q   <= 1'b0;
      out_sof_q   <= 1'b0;
      out_eol_q   <= 1'b0;
      stall_q     <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_bg_q    <= out_bg_d;
      out_ov_q    <= out_ov_d;
      out_sel_q   <= out_sel_d;
      out_sof_q   <= out_sof_d;
      out_eol_q   <= out_eol_d;
      stall_q     <= stall_d;
    end
  end

  assign BG_READ     = load;
  assign OV_READ     = load && need_ov;
  assign OUT_VALID   = out_valid_q;
  assign OUT_BG      = out_bg_q;
  assign OUT_OV      = out_ov_q;
  assign OUT_OV_SEL  = out_sel_q;
  assign OUT_SOF     = out_sof_q;
  assign OUT_EOL     = out_eol_q;
  assign FRAME_DONE  = (state_q == FRAME_END);
  assign STALL_COUNT = stall_q;

endmodule

// File: tb/tb_overlay_read_sequencer.sv
// Directed bench for overlay_read_sequencer on a 4x3 frame with a 2x1 window at (1,1).
module tb_overlay_read_sequencer;

  logic        CLK = 1'b0;
  logic        RESET, ENABLE, BG_EMPTY, OV_EMPTY, OUT_READY;
  logic [31:0] BG_DATA, OV_DATA;
  logic        BG_READ, OV_READ, OUT_VALID, OUT_OV_SEL, OUT_SOF, OUT_EOL, FRAME_DONE;
  logic [31:0] OUT_BG, OUT_OV;
  logic [15:0] STALL_COUNT;

  always #5 CLK = ~CLK;

  overlay_read_sequencer #(
    .DATA_WIDTH (32),
    .H_ACTIVE   (4),
    .V_ACTIVE   (3),
    .OVL_X      (1),
    .OVL_Y      (1),
    .OVL_W      (2),
    .OVL_H      (1)
  ) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .ENABLE      (ENABLE),
    .BG_EMPTY    (BG_EMPTY),
    .BG_DATA     (BG_DATA),
    .BG_READ     (BG_READ),
    .OV_EMPTY    (OV_EMPTY),
    .OV_DATA     (OV_DATA),
    .OV_READ     (OV_READ),
    .OUT_VALID   (OUT_VALID),
    .OUT_READY   (OUT_READY),
    .OUT_BG      (OUT_BG),
    .OUT_OV      (OUT_OV),
    .OUT_OV_SEL  (OUT_OV_SEL),
    .OUT_SOF     (OUT_SOF),
    .OUT_EOL     (OUT_EOL),
    .FRAME_DONE  (FRAME_DONE),
    .STALL_COUNT (STALL_COUNT)
  );

  // in: {ENABLE, BG_EMPTY, OV_EMPTY, OUT_READY}
  // rd: {BG_READ, OV_READ, OUT_VALID}
  // fl: {OUT_OV_SEL, OUT_SOF, OUT_EOL, FRAME_DONE}
  typedef struct {
    logic [3:0]  in;
    logic [2:0]  rd;
    logic [31:0] bg;
    logic [31:0] ov;
    logic [3:0]  fl;
  } vec_t;

  vec_t        tbl [15];
  int unsigned tests = 0;
  int unsigned fails = 0;
  int unsigned bg_ptr = 0;
  int unsigned ov_ptr = 0;
  logic        rd_bg, rd_ov;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock: present FIFO heads, capture pop strobes, then advance the FIFO models.
  task automatic step();
    BG_DATA = bg_ptr;
    OV_DATA = 32'd100 + ov_ptr;
    #1;
    rd_bg = BG_READ;
    rd_ov = OV_READ;
    @(posedge CLK);
    #1;
    if (rd_bg) bg_ptr++;
    if (rd_ov) ov_ptr++;
  endtask

  task automatic do_reset();
    RESET     = 1'b1;
    ENABLE    = 1'b0;
    BG_EMPTY  = 1'b0;
    OV_EMPTY  = 1'b0;
    OUT_READY = 1'b1;
    step();
    step();
    RESET  = 1'b0;
    bg_ptr = 0;
    ov_ptr = 0;
  endtask

  initial begin
    tbl[0]  = '{4'b1001, 3'b000, 32'd0,  32'd0,   4'b0000};
    tbl[1]  = '{4'b1001, 3'b101, 32'd0,  32'd0,   4'b0100};
    tbl[2]  = '{4'b1001, 3'b101, 32'd1,  32'd0,   4'b0000};
    tbl[3]  = '{4'b1001, 3'b101, 32'd2,  32'd0,   4'b0000};
    tbl[4]  = '{4'b1001, 3'b101, 32'd3,  32'd0,   4'b0010};
    tbl[5]  = '{4'b1001, 3'b101, 32'd4,  32'd0,   4'b0000};
    tbl[6]  = '{4'b1001, 3'b111, 32'd5,  32'd100, 4'b1000};
    tbl[7]  = '{4'b1001, 3'b111, 32'd6,  32'd101, 4'b1000};
    tbl[8]  = '{4'b1001, 3'b101, 32'd7,  32'd0,   4'b0010};
    tbl[9]  = '{4'b1001, 3'b101, 32'd8,  32'd0,   4'b0000};
    tbl[10] = '{4'b1001, 3'b101, 32'd9,  32'd0,   4'b0000};
    tbl[11] = '{4'b1001, 3'b101, 32'd10, 32'd0,   4'b0000};
    tbl[12] = '{4'b1001, 3'b101, 32'd11, 32'd0,   4'b0011};
    tbl[13] = '{4'b1001, 3'b000, 32'd0,  32'd0,   4'b0000};
    tbl[14] = '{4'b1001, 3'b101, 32'd12, 32'd0,   4'b0100};

    // Reset state
    do_reset();
    chk("rst.valid", 32'(OUT_VALID), 32'd0);
    chk("rst.bg", OUT_BG, 32'd0);
    chk("rst.ov", OUT_OV, 32'd0);
    chk("rst.flags", 32'({OUT_OV_SEL, OUT_SOF, OUT_EOL, FRAME_DONE}), 32'd0);
    chk("rst.stall", 32'(STALL_COUNT), 32'd0);

    // Full frame plus start of the next one
    for (int i = 0; i < 15; i++) begin
      {ENABLE, BG_EMPTY, OV_EMPTY, OUT_READY} = tbl[i].in;
      step();
      chk($sformatf("full[%0d].bg_read", i), 32'(rd_bg), 32'(tbl[i].rd[2]));
      chk($sformatf("full[%0d].ov_read", i), 32'(rd_ov), 32'(tbl[i].rd[1]));
      chk($sformatf("full[%0d].valid", i), 32'(OUT_VALID), 32'(tbl[i].rd[0]));
      if (tbl[i].rd[0]) begin
        chk($sformatf("full[%0d].out_bg", i), OUT_BG, tbl[i].bg);
        chk($sformatf("full[%0d].out_ov", i), OUT_OV, tbl[i].ov);
        chk($sformatf("full[%0d].sel_sof_eol", i), 32'({OUT_OV_SEL, OUT_SOF, OUT_EOL}),
            32'(tbl[i].fl[3:1]));
      end
      chk($sformatf("full[%0d].frame_done", i), 32'(FRAME_DONE), 32'(tbl[i].fl[0]));
    end
    chk("full.stall", 32'(STALL_COUNT), 32'd0);

    // Overlay starvation at (1,1)
    do_reset();
    ENABLE = 1'b1;
    step();
    repeat (5) step();
    chk("starve.pre_bg", OUT_BG, 32'd4);
    OV_EMPTY = 1'b1;
    for (int unsigned k = 1; k <= 3; k++) begin
      step();
      chk($sformatf("starve[%0d].bg_read", k), 32'(rd_bg), 32'd0);
      chk($sformatf("starve[%0d].ov_read", k), 32'(rd_ov), 32'd0);
      chk($sformatf("starve[%0d].stall", k), 32'(STALL_COUNT), k);
    end
    chk("starve.popped", 32'(OUT_VALID), 32'd0);
    OV_EMPTY = 1'b0;
    step();
    chk("starve.resume_reads", 32'({rd_bg, rd_ov}), 32'd3);
    chk("starve.resume_bg", OUT_BG, 32'd5);
    chk("starve.resume_ov", OUT_OV, 32'd100);
    chk("starve.resume_sel", 32'(OUT_OV_SEL), 32'd1);
    step();
    chk("starve.next_bg", OUT_BG, 32'd6);
    chk("starve.next_ov", OUT_OV, 32'd101);
    chk("starve.stall_hold", 32'(STALL_COUNT), 32'd3);

    // Backpressure mid-line
    do_reset();
    ENABLE = 1'b1;
    repeat (3) step();
    chk("bp.pre_bg", OUT_BG, 32'd1);
    OUT_READY = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("bp[%0d].read", k), 32'({rd_bg, rd_ov}), 32'd0);
      chk($sformatf("bp[%0d].hold", k), 32'({OUT_VALID, OUT_OV_SEL, OUT_SOF, OUT_EOL}), 32'd8);
      chk($sformatf("bp[%0d].bg", k), OUT_BG, 32'd1);
    end
    chk("bp.stall", 32'(STALL_COUNT), 32'd0);
    OUT_READY = 1'b1;
    step();
    chk("bp.release_read", 32'(rd_bg), 32'd1);
    chk("bp.release_bg", OUT_BG, 32'd2);
    chk("bp.release_valid", 32'(OUT_VALID), 32'd1);

    // ENABLE dropped at pixel 4
    do_reset();
    ENABLE = 1'b1;
    step();
    repeat (4) step();
    ENABLE = 1'b0;
    repeat (8) step();
    chk("endrop.last_bg", OUT_BG, 32'd11);
    chk("endrop.done", 32'(FRAME_DONE), 32'd1);
    step();
    chk("endrop.done_pulse", 32'(FRAME_DONE), 32'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("endrop.idle[%0d].read", k), 32'({rd_bg, rd_ov}), 32'd0);
      chk($sformatf("endrop.idle[%0d].valid", k), 32'(OUT_VALID), 32'd0);
    end
    chk("endrop.bg_pops", bg_ptr, 32'd12);
    chk("endrop.ov_pops", ov_ptr, 32'd2);

    // Reset at pixel 6 after some starved cycles
    do_reset();
    ENABLE = 1'b1;
    step();
    repeat (6) step();
    chk("midrst.pre_bg", OUT_BG, 32'd5);
    BG_EMPTY = 1'b1;
    step();
    step();
    chk("midrst.pre_stall", 32'(STALL_COUNT), 32'd2);
    BG_EMPTY = 1'b0;
    RESET = 1'b1;
    step();
    chk("midrst.reads", 32'({rd_bg, rd_ov}), 32'd0);
    chk("midrst.valid", 32'(OUT_VALID), 32'd0);
    chk("midrst.stall", 32'(STALL_COUNT), 32'd0);
    RESET  = 1'b0;
    bg_ptr = 0;
    ov_ptr = 0;
    step();
    chk("midrst.idle_read", 32'(rd_bg), 32'd0);
    step();
    chk("midrst.first_reads", 32'({rd_bg, rd_ov}), 32'd2);
    chk("midrst.sof", 32'({OUT_VALID, OUT_SOF, OUT_OV_SEL}), 32'd6);
    chk("midrst.bg", OUT_BG, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/overlay_read_sequencer.md
# overlay_read_sequencer

Sequences reads from the two first-word-fall-through pixel FIFOs of the overlay path: background video and overlay graphics. It walks a raster of the active frame and pops a background pixel every pixel. It pops an overlay pixel only for positions inside the overlay window. Each result is presented to the downstream mixer as one registered, handshaked pixel pair with frame and line markers. It sits between the two input FIFOs and the alpha or select mixer.

## Interface
Parameters:
- DATA_WIDTH, 32, pixel word width of both FIFOs
- H_ACTIVE, 640, active pixels per line
- V_ACTIVE, 480, active lines per frame
- OVL_X, 0, first overlay column
- OVL_Y, 0, first overlay line
- OVL_W, 64, overlay width in pixels
- OVL_H, 64, overlay height in lines

Ports:
- CLK, input, 1, the single clock
- RESET, input, 1, synchronous, active-high
- ENABLE, input, 1, permits a frame to start
- BG_EMPTY, input, 1, background FIFO empty
- BG_DATA, input, DATA_WIDTH, background FIFO head word
- BG_READ, output, 1, pop background FIFO
- OV_EMPTY, input, 1, overlay FIFO empty
- OV_DATA, input, DATA_WIDTH, overlay FIFO head word
- OV_READ, output, 1, pop overlay FIFO
- OUT_VALID, output, 1, pixel pair valid
- OUT_READY, input, 1, mixer accepts the pair
- OUT_BG, output, DATA_WIDTH, background pixel
- OUT_OV, output, DATA_WIDTH, overlay pixel; 0 outside the window
- OUT_OV_SEL, output, 1, pixel lies inside the overlay window
- OUT_SOF, output, 1, first pixel of the frame (x=0, y=0)
- OUT_EOL, output, 1, last pixel of the line (x=H_ACTIVE-1)
- FRAME_DONE, output, 1, one-cycle pulse after the last pixel is loaded
- STALL_COUNT, output, 16, saturating count of starved cycles

## Operation
- The state machine has three states: IDLE, ACTIVE and FRAME_END.
- IDLE -> ACTIVE when ENABLE=1. The counters x and y are 0.
- ACTIVE:
  - "slot free" means OUT_VALID=0 or OUT_READY=1.
  - inwin means OVL_X ≤ x < OVL_X+OVL_W and OVL_Y ≤ y < OVL_Y+OVL_H.
  - "need_ov" is inwin.
  - "load" is slot free, BG_EMPTY=0, and (need_ov=0 or OV_EMPTY=0), all together.
- On load:
  - BG_READ=1 for that cycle.
  - OV_READ=need_ov for that cycle.
  - The output register takes BG_DATA, then OV_DATA if need_ov else 0, then need_ov, (x==0 and y==0), and (x==H_ACTIVE-1).
  - x increments. At H_ACTIVE-1, x wraps to 0 and y increments.
  - On the last pixel (x=H_ACTIVE-1, y=V_ACTIVE-1), the next state is FRAME_END and x, y return to 0.
- Starved cycle: ACTIVE, slot free, and not load. STALL_COUNT increments and saturates at 16'hFFFF. It is cleared only by RESET.
- FRAME_END:
  - FRAME_DONE=1 for exactly this cycle.
  - Next state is ACTIVE if ENABLE=1, else IDLE.
  - No load occurs in this state.
- ENABLE is sampled only in IDLE and FRAME_END. Deasserting it mid-frame has no effect until the frame completes.
- Output pop: when OUT_VALID=1, OUT_READY=1 and there is no load, OUT_VALID goes to 0 next cycle.
- Output hold: OUT_* stays stable while OUT_VALID=1 and OUT_READY=0.
- Window arithmetic:
  - Comparisons use counter-width unsigned values, widened by one bit for OVL_X+OVL_W and OVL_Y+OVL_H.
  - A window extending past the frame is clipped.
  - OVL_W=0 or OVL_H=0 means OV_READ is never asserted.
- Counter widths are $clog2(H_ACTIVE) and $clog2(V_ACTIVE), each with a minimum of 1.

## Timing
- BG_READ and OV_READ are combinational from state, counters and the FIFO flags. They are only high in the cycle in which the head word is captured.
- Latency: one cycle from a FIFO word being present (EMPTY=0) with slot free to OUT_VALID=1.
- Throughput: one pair per clock while both FIFOs are non-empty and OUT_READY=1. Load and pop in the same cycle are allowed.
- The overlay FIFO is never popped outside the window, even when it is non-empty.
- The background is never popped alone inside the window. Both pop together or neither pops.
- Reset values:
  - state IDLE, x=0, y=0.
  - OUT_VALID=0, OUT_BG=0, OUT_OV=0, OUT_OV_SEL=0, OUT_SOF=0, OUT_EOL=0.
  - FRAME_DONE=0, STALL_COUNT=0.
- Reset mid-frame: BG_READ and OV_READ are 0 in the reset cycle, and all registers return to their reset values. The FIFOs are reset separately by the system.

## Structure
- The shared overlay package holds:
  - the state encoding constants IDLE=2'd0, ACTIVE=2'd1, FRAME_END=2'd2
  - the STALL_COUNT width (16)
  - the default frame geometry constants
- One sub-module, pixel_position_counter:
  - holds the x/y raster counters with an advance input
  - provides a last-pixel flag, an end-of-line flag and inwin, parameterised by the geometry
- The FSM, the load logic and the output register live in the top module.

## Test plan
All scenarios use H_ACTIVE=4, V_ACTIVE=3, OVL_X=1, OVL_Y=1, OVL_W=2, OVL_H=1.
- **Full frame:** both FIFOs are always non-empty, BG words 0..11, OV words 100,101, OUT_READY=1, ENABLE=1.
  - 12 consecutive pairs appear.
  - OV_SEL=1 only on pixels 5 and 6, with OUT_OV=100 then 101.
  - OUT_SOF is set on pixel 0 and OUT_EOL on pixels 3, 7 and 11.
  - FRAME_DONE fires once, then the next frame starts.
- **Overlay starvation:** OV_EMPTY=1 while at x=1, y=1.
  - No BG_READ occurs while starved, and STALL_COUNT increments once per cycle.
  - The frame resumes when OV_EMPTY=0, with the BG order intact.
- **Backpressure:** OUT_READY=0 for 5 cycles mid-line.
  - OUT_* holds its values and no reads occur.
  - On release, the next pixel loads in the same cycle as the pop.
- **ENABLE dropped mid-frame:** ENABLE=0 at pixel 4.
  - The frame completes all 12 pixels, then FRAME_END -> IDLE.
  - No further reads occur.
- **Reset mid-frame:** RESET=1 for one cycle at pixel 6.
  - OUT_VALID=0, STALL_COUNT=0 and the counters are 0 afterwards.
  - With ENABLE=1 the next frame begins at SOF.
